muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Sequencing stage between the EX stage and the iterative multiply/divide units.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and launches the selected unit with a one-cycle start pulse.
- Waits for the unit's completion pulse, commits HI/LO into architectural registers, and raises a pipeline stall while a read of HI/LO would see stale data.

Parameters:
- WIDTH, 32, operand and HI/LO width
- TIMEOUT, 40, watchdog limit in cycles in WAIT; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  clock enable; when low, all state holds
- op_valid  in  1  EX presents an operation this cycle
- op_code  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 ignored
- rs_val  in  WIDTH  operand A / MTHI/MTLO source
- rt_val  in  WIDTH  operand B
- hilo_read  in  1  EX/ID is executing MFHI or MFLO
- op_ready  out  1  controller can accept an operation
- stall  out  1  freeze the pipeline front end
- unit_start  out  1  one-cycle launch pulse to the selected unit
- unit_sel  out  1  0=multiplier, 1=divider
- unit_signed  out  1  signed operation
- unit_opa  out  WIDTH  latched operand A
- unit_opb  out  WIDTH  latched operand B
- unit_done  in  1  one-cycle result-valid pulse from the selected unit
- unit_hi  in  WIDTH  unit HI result
- unit_lo  in  WIDTH  unit LO result
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- timeout_err  out  1  sticky watchdog flag; optional feature only

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - hi=0, lo=0, state=IDLE.
  - unit_start=0, unit_sel=0, unit_signed=0, unit_opa=0, unit_opb=0.
  - op_ready=1, stall=0, timeout_err=0.
  - An in-flight unit result that arrives after reset is ignored.
- States: IDLE, LAUNCH, WAIT, COMMIT.
- IDLE, op_valid=1:
  - op_code 4/5: write hi (MTHI) or lo (MTLO) with rs_val on that edge; stay in IDLE.
  - op_code 0-3: latch operands, unit_sel = op_code[1], unit_signed = ~op_code[0]; go to LAUNCH.
  - op_code 6-7: no effect.
- DIV/DIVU with rt_val=0: the unit is not launched. Go straight to COMMIT with hi=rs_val and lo={WIDTH{1}}.
- LAUNCH: unit_start=1 for exactly this cycle; next state WAIT.
- WAIT:
  - Hold until unit_done=1, then capture unit_hi/unit_lo into holding registers and go to COMMIT.
  - A unit_done seen in LAUNCH or IDLE is ignored.
- COMMIT: write the holding registers to hi/lo on this edge; next state IDLE.
- Latency: hi/lo visible 3 cycles after the unit's done pulse arrives relative to acceptance, i.e. accept edge + LAUNCH + WAIT(n) + COMMIT.
- op_ready = (state==IDLE).
- stall = op_valid & ~op_ready, OR hilo_read & (state != IDLE).
  - MFHI/MFLO never sees a partially updated pair.
- op_valid while busy: EX holds the operation stable until op_ready; no queueing.
- clk_en=0 freezes state, outputs, and the watchdog counter. A unit_done pulse arriving while clk_en=0 is lost; units share clk_en, so this cannot occur.

Optional Feature:
- Macro: MULDIV_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each enabled cycle in WAIT.
  - When it reaches TIMEOUT: set timeout_err (sticky until rst), commit hi=0 and lo=0 through COMMIT, and return to IDLE.
- Undefined: no counter; WAIT is unbounded; timeout_err is tied 0.

Test Plan:
- Reset with op pending mid-WAIT: assert rst asynchronously -> hi=lo=0, op_ready=1, stall=0 within the same cycle.
- MULT with rs=0xFFFFFFFE (-2), rt=3; unit returns done with hi=0xFFFFFFFF, lo=0xFFFFFFFA after 32 cycles:
  - unit_start pulses once with unit_sel=0, unit_signed=1.
  - hi/lo update on the edge after COMMIT.
  - stall held while hilo_read=1.
- DIVU with rs=100, rt=0 -> unit_start never asserts; hi=100, lo=0xFFFFFFFF after 2 cycles.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles in IDLE -> hi/lo updated one edge each, stall=0 throughout.
- Back-to-back MULTU held during busy: op_valid=1 in WAIT -> stall=1, no second unit_start until the first COMMIT, then accepted in IDLE.
- With MULDIV_TIMEOUT_EN and TIMEOUT=40, unit_done never arrives -> timeout_err=1 at WAIT cycle 40, hi=lo=0, op_ready=1 the cycle after COMMIT.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer between EX and the iterative multiply/divide units; owns architectural HI/LO.
// Optional WAIT watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_hilo_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_read,
  output logic             op_ready,
  output logic             stall,
  output logic             unit_start,
  output logic             unit_sel,
  output logic             unit_signed,
  output logic [WIDTH-1:0] unit_opa,
  output logic [WIDTH-1:0] unit_opb,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_hi,
  input  logic [WIDTH-1:0] unit_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StCommit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hold_hi_q, hold_hi_d, hold_lo_q, hold_lo_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic             sel_q, sel_d, sgn_q, sgn_d;
`ifdef MULDIV_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic             unused_cfg;
  assign unused_cfg = ^TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hold_hi_d = hold_hi_q;
    hold_lo_d = hold_lo_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sel_d     = sel_q;
    sgn_d     = sgn_q;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          if (op_code == 3'd4) begin
            hi_d = rs_val;
          end else if (op_code == 3'd5) begin
            lo_d = rs_val;
          end else if (!op_code[2]) begin
            opa_d = rs_val;
            opb_d = rt_val;
            sel_d = op_code[1];
            sgn_d = ~op_code[0];
            // Divide by zero bypasses the unit with a fixed architectural result.
            if (op_code[1] && (rt_val == '0)) begin
              hold_hi_d = rs_val;
              hold_lo_d = '1;
              state_d   = StCommit;
            end else begin
              state_d   = StLaunch;
            end
          end
        end
      end
      StLaunch: begin
        state_d = StWait;
`ifdef MULDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (unit_done) begin
          hold_hi_d = unit_hi;
          hold_lo_d = unit_lo;
          state_d   = StCommit;
        end
`ifdef MULDIV_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(TIMEOUT)) begin
            err_d     = 1'b1;
            hold_hi_d = '0;
            hold_lo_d = '0;
            state_d   = StCommit;
          end
        end
`endif
      end
      StCommit: begin
        hi_d    = hold_hi_q;
        lo_d    = hold_lo_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      hold_hi_q <= '0;
      hold_lo_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sel_q     <= 1'b0;
      sgn_q     <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hold_hi_q <= hold_hi_d;
      hold_lo_q <= hold_lo_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sel_q     <= sel_d;
      sgn_q     <= sgn_d;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign op_ready    = (state_q == StIdle);
  assign stall       = (op_valid & ~op_ready) | (hilo_read & (state_q != StIdle));
  assign unit_start  = (state_q == StLaunch);
  assign unit_sel    = sel_q;
  assign unit_signed = sgn_q;
  assign unit_opa    = opa_q;
  assign unit_opb    = opb_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
`ifdef MULDIV_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed self-checking bench for muldiv_hilo_ctrl; the bench plays the role of the unit.
module tb_muldiv_hilo_ctrl;
  localparam int unsigned W = 32;

  logic         clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  logic         op_valid = 1'b0, hilo_read = 1'b0, unit_done = 1'b0;
  logic [2:0]   op_code = 3'd0;
  logic [W-1:0] rs_val = '0, rt_val = '0, unit_hi = '0, unit_lo = '0;
  logic         op_ready, stall, unit_start, unit_sel, unit_signed, timeout_err;
  logic [W-1:0] unit_opa, unit_opb, hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int s0;

  muldiv_hilo_ctrl #(.WIDTH(W), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .hilo_read(hilo_read), .op_ready(op_ready),
    .stall(stall), .unit_start(unit_start), .unit_sel(unit_sel), .unit_signed(unit_signed),
    .unit_opa(unit_opa), .unit_opb(unit_opb), .unit_done(unit_done), .unit_hi(unit_hi),
    .unit_lo(unit_lo), .hi(hi), .lo(lo), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (unit_start) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12 rst = 1'b0;
    tick();
    n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", op_ready); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (unit_start !== 1'b0) $display("FAIL reset_start got %b want 0", unit_start); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_terr got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_mult();
    s0 = start_cnt;
    op_valid = 1'b1; op_code = 3'd0; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    tick();
    op_valid = 1'b0; hilo_read = 1'b1;
    #1;
    n_checks++; if (unit_start !== 1'b1) $display("FAIL mult_start got %b want 1", unit_start); else n_pass++;
    n_checks++; if (unit_sel !== 1'b0) $display("FAIL mult_sel got %b want 0", unit_sel); else n_pass++;
    n_checks++; if (unit_signed !== 1'b1) $display("FAIL mult_signed got %b want 1", unit_signed); else n_pass++;
    n_checks++; if (unit_opa !== 32'hFFFF_FFFE) $display("FAIL mult_opa got %h want fffffffe", unit_opa); else n_pass++;
    n_checks++; if (unit_opb !== 32'd3) $display("FAIL mult_opb got %h want 3", unit_opb); else n_pass++;
    n_checks++; if (stall !== 1'b1) $display("FAIL mult_stall_launch got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (unit_start !== 1'b0) $display("FAIL mult_start_wait got %b want 0", unit_start); else n_pass++;
    repeat (31) tick();
    unit_done = 1'b1; unit_hi = 32'hFFFF_FFFF; unit_lo = 32'hFFFF_FFFA;
    tick();
    unit_done = 1'b0;
    n_checks++; if (hi !== 32'h0) $display("FAIL mult_hi_early got %h want 0", hi); else n_pass++;
    n_checks++; if (stall !== 1'b1) $display("FAIL mult_stall_commit got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h want fffffffa", lo); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL mult_stall_idle got %b want 0", stall); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 1) $display("FAIL mult_start_count got %0d want 1", start_cnt - s0); else n_pass++;
    hilo_read = 1'b0;
  endtask

  task automatic test_divzero();
    s0 = start_cnt;
    op_valid = 1'b1; op_code = 3'd3; rs_val = 32'd100; rt_val = 32'd0;
    tick();
    op_valid = 1'b0;
    n_checks++; if (op_ready !== 1'b0) $display("FAIL dz_ready got %b want 0", op_ready); else n_pass++;
    n_checks++; if (unit_start !== 1'b0) $display("FAIL dz_start got %b want 0", unit_start); else n_pass++;
    tick();
    n_checks++; if (hi !== 32'd100) $display("FAIL dz_hi got %h want 64", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL dz_lo got %h want ffffffff", lo); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL dz_ready_after got %b want 1", op_ready); else n_pass++;
    tick();
    n_checks++; if (start_cnt !== s0) $display("FAIL dz_no_launch got %0d want %0d", start_cnt, s0); else n_pass++;
  endtask

  task automatic test_mthi_mtlo();
    op_valid = 1'b1; op_code = 3'd4; rs_val = 32'h1234_5678;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL mthi_stall got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi got %h want 12345678", hi); else n_pass++;
    op_code = 3'd5; rs_val = 32'h9ABC_DEF0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL mtlo_stall got %b want 0", stall); else n_pass++;
    tick();
    op_valid = 1'b0;
    n_checks++; if (lo !== 32'h9ABC_DEF0) $display("FAIL mtlo_lo got %h want 9abcdef0", lo); else n_pass++;
    n_checks++; if (hi !== 32'h1234_5678) $display("FAIL mtlo_hi_kept got %h want 12345678", hi); else n_pass++;
  endtask

  task automatic test_ignored();
    op_valid = 1'b1; op_code = 3'd6; rs_val = 32'h5555_5555; rt_val = 32'd1;
    tick();
    op_valid = 1'b0;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL op6_ready got %b want 1", op_ready); else n_pass++;
    n_checks++; if (hi !== 32'h1234_5678) $display("FAIL op6_hi got %h want 12345678", hi); else n_pass++;
    unit_done = 1'b1; unit_hi = 32'h5; unit_lo = 32'h6;
    tick();
    unit_done = 1'b0;
    tick();
    n_checks++; if (op_ready !== 1'b1) $display("FAIL idle_done_ready got %b want 1", op_ready); else n_pass++;
    n_checks++; if (lo !== 32'h9ABC_DEF0) $display("FAIL idle_done_lo got %h want 9abcdef0", lo); else n_pass++;
    clk_en = 1'b0; op_valid = 1'b1; op_code = 3'd4; rs_val = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (hi !== 32'h1234_5678) $display("FAIL clken_hi got %h want 12345678", hi); else n_pass++;
    op_valid = 1'b0; clk_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    s0 = start_cnt;
    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd7; rt_val = 32'd6;
    tick();
    n_checks++; if (unit_signed !== 1'b0) $display("FAIL b2b_signed got %b want 0", unit_signed); else n_pass++;
    n_checks++; if (unit_start !== 1'b1) $display("FAIL b2b_start got %b want 1", unit_start); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b1) $display("FAIL b2b_stall_wait got %b want 1", stall); else n_pass++;
    repeat (5) tick();
    n_checks++; if (start_cnt - s0 !== 1) $display("FAIL b2b_one_start got %0d want 1", start_cnt - s0); else n_pass++;
    unit_done = 1'b1; unit_hi = 32'd0; unit_lo = 32'd42;
    tick();
    unit_done = 1'b0;
    n_checks++; if (stall !== 1'b1) $display("FAIL b2b_stall_commit got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (lo !== 32'd42) $display("FAIL b2b_lo got %h want 2a", lo); else n_pass++;
    n_checks++; if (hi !== 32'd0) $display("FAIL b2b_hi got %h want 0", hi); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL b2b_stall_idle got %b want 0", stall); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 1) $display("FAIL b2b_start_before got %0d want 1", start_cnt - s0); else n_pass++;
    tick();
    op_valid = 1'b0;
    n_checks++; if (unit_start !== 1'b1) $display("FAIL b2b_second_start got %b want 1", unit_start); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    hilo_read = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (hi !== 32'h0) $display("FAIL rmw_hi got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL rmw_lo got %h want 0", lo); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL rmw_ready got %b want 1", op_ready); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rmw_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (unit_opa !== 32'h0) $display("FAIL rmw_opa got %h want 0", unit_opa); else n_pass++;
    #1 rst = 1'b0;
    hilo_read = 1'b0;
    unit_done = 1'b1; unit_hi = 32'hAAAA_AAAA; unit_lo = 32'hBBBB_BBBB;
    tick();
    unit_done = 1'b0;
    tick();
    n_checks++; if (hi !== 32'h0) $display("FAIL rmw_late_done_hi got %h want 0", hi); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL rmw_late_ready got %b want 1", op_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divzero();
    test_mthi_mtlo();
    test_ignored();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
